// File: rtl/hex_display_mux_if.sv
// Bus between register/status logic (master) and the 7-segment driver (slave).
// Signal names match the board-level port names of the driver.
interface hex_display_mux_if #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned BRIGHT_WIDTH = 4
);
  logic [4*NUM_DIGITS-1:0] i_data;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic                    i_load;
  logic [BRIGHT_WIDTH-1:0] i_brightness;
  logic                    i_blank_lz;
  logic [NUM_DIGITS-1:0]   o_anodes;
  logic [7:0]              o_segments;
  logic                    o_frame;
  logic                    o_pending;

  modport master (
    output i_data, i_dp, i_load, i_brightness, i_blank_lz,
    input  o_anodes, o_segments, o_frame, o_pending
  );

  modport slave (
    input  i_data, i_dp, i_load, i_brightness, i_blank_lz,
    output o_anodes, o_segments, o_frame, o_pending
  );
endinterface

// File: rtl/hex_display_mux.sv
// Multiplexed common-anode 7-segment driver: PWM brightness, leading-zero blanking and
// frame-synchronous data update. Define HEX_DISPLAY_DP_EN to enable per-digit decimal points.
module hex_display_mux #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned CNT_WIDTH    = 14,
  parameter int unsigned BRIGHT_WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  hex_display_mux_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] stage_data_q, shadow_data_q;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending_q;
  logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
  logic [7:0]              segments_q, segments_d;
  logic                    frame_q;
  logic                    frame_bnd, take;
  logic [NUM_DIGITS-1:0]   keep;
  logic                    keep_acc;
  logic [3:0]              nibble;
  logic                    pwm_on, lit;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hFC;
      4'h1: s = 8'h60;
      4'h2: s = 8'hDA;
      4'h3: s = 8'hF2;
      4'h4: s = 8'h66;
      4'h5: s = 8'hB6;
      4'h6: s = 8'hBE;
      4'h7: s = 8'hE0;
      4'h8: s = 8'hFE;
      4'h9: s = 8'hF6;
      4'hA: s = 8'hEE;
      4'hB: s = 8'h3E;
      4'hC: s = 8'h9C;
      4'hD: s = 8'h7A;
      4'hE: s = 8'h9E;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign frame_bnd = (&cnt_q) && (idx_q == LAST_IDX);
  // A load on the boundary itself is forwarded straight into the shadow.
  assign take      = frame_bnd && (pending_q || bus.i_load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_data_q  <= '0;
      shadow_data_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      if (bus.i_load) begin
        stage_data_q <= bus.i_data;
      end
      if (take) begin
        shadow_data_q <= bus.i_load ? bus.i_data : stage_data_q;
        pending_q     <= 1'b0;
      end else if (bus.i_load) begin
        pending_q <= 1'b1;
      end
    end
  end

`ifdef HEX_DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0] stage_dp_q, shadow_dp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_dp_q  <= '0;
      shadow_dp_q <= '0;
    end else begin
      if (bus.i_load) begin
        stage_dp_q <= bus.i_dp;
      end
      if (take) begin
        shadow_dp_q <= bus.i_load ? bus.i_dp : stage_dp_q;
      end
    end
  end

  assign shadow_dp = shadow_dp_q;
`else
  logic unused_dp;
  assign unused_dp = ^bus.i_dp;
  assign shadow_dp = '0;
`endif

  // keep[k]: some digit at or left of k carries a non-zero nibble or a dp.
  always_comb begin
    keep     = '0;
    keep_acc = 1'b0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      keep_acc = keep_acc | (shadow_data_q[4*k +: 4] != 4'h0) | shadow_dp[k];
      keep[k]  = keep_acc;
    end
  end

  always_comb begin
    nibble     = shadow_data_q[idx_q*4 +: 4];
    pwm_on     = cnt_q[CNT_WIDTH-1 -: BRIGHT_WIDTH] < bus.i_brightness;
    lit        = pwm_on && !(bus.i_blank_lz && (idx_q != '0) && !keep[idx_q]);
    anodes_d   = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    segments_d = lit ? (seg_decode(nibble) | {7'b0, shadow_dp[idx_q]}) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodes_q   <= '1;
      segments_q <= '0;
      frame_q    <= 1'b0;
    end else begin
      anodes_q   <= anodes_d;
      segments_q <= segments_d;
      frame_q    <= frame_bnd;
    end
  end

  assign bus.o_anodes   = anodes_q;
  assign bus.o_segments = segments_q;
  assign bus.o_frame    = frame_q;
  assign bus.o_pending  = pending_q;
endmodule

// File: tb/tb_hex_display_mux.sv
// Frame-level scoreboard bench for hex_display_mux (4 digits) plus a 3-digit scan check.
module tb_hex_display_mux;
  localparam int unsigned ND = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned BW = 4;
  localparam int FRAME_CYC = ND * (1 << CW);

  typedef struct packed {
    logic [ND-1:0][4:0] lit;
    logic [ND-1:0][7:0] seg;
    logic               pend;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hex_display_mux_if #(.NUM_DIGITS(ND), .BRIGHT_WIDTH(BW)) bus ();
  hex_display_mux #(.NUM_DIGITS(ND), .CNT_WIDTH(CW), .BRIGHT_WIDTH(BW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  hex_display_mux_if #(.NUM_DIGITS(3), .BRIGHT_WIDTH(BW)) bus3 ();
  hex_display_mux #(.NUM_DIGITS(3), .CNT_WIDTH(CW), .BRIGHT_WIDTH(BW)) dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3)
  );

  int n_checks = 0;
  int n_pass = 0;
  int unsigned frames_seen = 0;
  logic dut3_done = 1'b0;
  frame_t exp_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic frame_t mk(input int l3, input int l2, input int l1, input int l0,
                                input logic [31:0] segs, input logic pend);
    frame_t f;
    f.lit[3] = 5'(l3);
    f.lit[2] = 5'(l2);
    f.lit[1] = 5'(l1);
    f.lit[0] = 5'(l0);
    f.seg    = segs;
    f.pend   = pend;
    return f;
  endfunction

  // Monitor: accumulates one displayed frame, closes it on o_frame and scores it.
  int                 cyc;
  logic [ND-1:0][4:0] lit_obs;
  logic [ND-1:0][7:0] seg_obs;
  logic               pend_obs, glitch, hit;

  task automatic clear_obs();
    cyc = 0; lit_obs = '0; seg_obs = '0; pend_obs = 1'b0; glitch = 1'b0;
  endtask

  initial begin
    frame_t e;
    clear_obs();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        clear_obs();
      end else begin
        cyc++;
        pend_obs = pend_obs | bus.o_pending;
        if (bus.o_anodes == '1) begin
          if (bus.o_segments != 8'h00) glitch = 1'b1;
        end else begin
          hit = 1'b0;
          for (int k = 0; k < ND; k++) begin
            if (bus.o_anodes == ~(ND'(1) << k)) begin
              if (lit_obs[k] != 0 && seg_obs[k] != bus.o_segments) glitch = 1'b1;
              lit_obs[k] = lit_obs[k] + 5'd1;
              seg_obs[k] = bus.o_segments;
              hit = 1'b1;
            end
          end
          if (!hit) glitch = 1'b1;
        end
        if (bus.o_frame) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("frame%0d period", frames_seen), cyc, FRAME_CYC);
            for (int k = 0; k < ND; k++) begin
              check($sformatf("frame%0d digit%0d lit cycles", frames_seen, k),
                    lit_obs[k], e.lit[k]);
              if (e.lit[k] != 0)
                check($sformatf("frame%0d digit%0d segments", frames_seen, k),
                      seg_obs[k], e.seg[k]);
            end
            check($sformatf("frame%0d pending seen", frames_seen), pend_obs, e.pend);
            check($sformatf("frame%0d anode/segment glitch", frames_seen), glitch, 0);
          end
          clear_obs();
          frames_seen++;
        end
      end
    end
  end

  task automatic wait_frames(input int n);
    int unsigned target = frames_seen + n;
    int budget = (n + 4) * FRAME_CYC;
    while (frames_seen < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (frames_seen < target) check("frame wait timeout", frames_seen, target);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    bus.i_data = d;
    bus.i_dp   = dp;
    bus.i_load = 1'b1;
    @(posedge clk);
    #1;
    bus.i_load = 1'b0;
  endtask

  // 3-digit instance: index 0,1,2,0 and a frame every 48 clocks.
  initial begin
    int guard = 0;
    int d;
    logic on;
    logic [2:0] exp_an;
    @(posedge rst_n);
    do begin
      @(negedge clk);
      guard++;
    end while (!bus3.o_frame && guard < 200);
    check("dut3 first frame seen", bus3.o_frame, 1);
    for (int j = 0; j < 48; j++) begin
      @(negedge clk);
      d = j / 16;
      on = (j % 16) != 15;
      exp_an = on ? ~(3'b001 << d) : 3'b111;
      check($sformatf("dut3 anodes cycle %0d", j), bus3.o_anodes, exp_an);
      if (j % 16 == 0) check($sformatf("dut3 segments cycle %0d", j), bus3.o_segments, 8'hFC);
      if (j == 15 || j == 47) check($sformatf("dut3 frame cycle %0d", j), bus3.o_frame, j == 47);
    end
    dut3_done = 1'b1;
  end

  initial begin
    bus.i_data = '0; bus.i_dp = '0; bus.i_load = 1'b0; bus.i_brightness = '0;
    bus.i_blank_lz = 1'b0;
    bus3.i_data = '0; bus3.i_dp = '0; bus3.i_load = 1'b0; bus3.i_brightness = 4'd15;
    bus3.i_blank_lz = 1'b0;

    repeat (3) @(negedge clk);
    check("reset anodes", bus.o_anodes, 4'hF);
    check("reset segments", bus.o_segments, 8'h00);
    check("reset frame", bus.o_frame, 0);
    check("reset pending", bus.o_pending, 0);
    rst_n = 1'b1;

    // Brightness 0: dark throughout.
    wait_frames(1);
    exp_q.push_back(mk(0, 0, 0, 0, 32'h0, 0));
    exp_q.push_back(mk(0, 0, 0, 0, 32'h0, 0));
    wait_frames(2);

    // Full brightness, load 12A4; shown from the frame after the load.
    bus.i_brightness = 4'd15;
    exp_q.push_back(mk(15, 15, 15, 15, 32'hFCFCFCFC, 1));
    load(16'h12A4, 4'h0);
    wait_frames(1);
    exp_q.push_back(mk(15, 15, 15, 15, 32'h60DAEE66, 0));
    wait_frames(1);

    bus.i_brightness = 4'd5;
    exp_q.push_back(mk(5, 5, 5, 5, 32'h60DAEE66, 0));
    wait_frames(1);
    bus.i_brightness = 4'd15;

    // Tear-free update: FFFF shown, 0000 loaded mid-frame.
    exp_q.push_back(mk(15, 15, 15, 15, 32'h60DAEE66, 1));
    load(16'hFFFF, 4'h0);
    wait_frames(1);
    exp_q.push_back(mk(15, 15, 15, 15, 32'h8E8E8E8E, 0));
    wait_frames(1);
    exp_q.push_back(mk(15, 15, 15, 15, 32'h8E8E8E8E, 1));
    repeat (20) @(posedge clk);
    #1;
    load(16'h0000, 4'h0);
    wait_frames(1);
    exp_q.push_back(mk(15, 15, 15, 15, 32'hFCFCFCFC, 0));
    wait_frames(1);

    // Load coincident with the frame boundary: displayed next frame, pending never set.
    exp_q.push_back(mk(15, 15, 15, 15, 32'hFCFCFCFC, 0));
    repeat (63) @(posedge clk);
    #1;
    load(16'h3C07, 4'h0);
    exp_q.push_back(mk(15, 15, 15, 15, 32'hF29CFCE0, 0));
    wait_frames(2);

    // Leading-zero blanking.
    bus.i_blank_lz = 1'b1;
    exp_q.push_back(mk(15, 15, 15, 15, 32'hF29CFCE0, 1));
    load(16'h0050, 4'h0);
    wait_frames(1);
    exp_q.push_back(mk(0, 0, 15, 15, 32'h0000B6FC, 0));
    wait_frames(1);
    exp_q.push_back(mk(0, 0, 15, 15, 32'h0000B6FC, 1));
    load(16'h0000, 4'h0);
    wait_frames(1);
    exp_q.push_back(mk(0, 0, 0, 15, 32'h000000FC, 0));
    wait_frames(1);

    // Decimal point on digit 3 with zero data.
    exp_q.push_back(mk(0, 0, 0, 15, 32'h000000FC, 1));
    load(16'h0000, 4'b1000);
    wait_frames(1);
`ifdef HEX_DISPLAY_DP_EN
    exp_q.push_back(mk(15, 15, 15, 15, 32'hFDFCFCFC, 0));
`else
    exp_q.push_back(mk(0, 0, 0, 15, 32'h000000FC, 0));
`endif
    wait_frames(1);

    // Reset mid-frame with data pending: immediate reset values, staging discarded.
    load(16'h8888, 4'h0);
    repeat (10) @(posedge clk);
    #1;
    check("pre-reset pending", bus.o_pending, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset anodes", bus.o_anodes, 4'hF);
    check("mid reset segments", bus.o_segments, 8'h00);
    check("mid reset frame", bus.o_frame, 0);
    check("mid reset pending", bus.o_pending, 0);
    @(negedge clk);
    bus.i_blank_lz = 1'b0;
    rst_n = 1'b1;
    wait_frames(1);
    exp_q.push_back(mk(15, 15, 15, 15, 32'hFCFCFCFC, 0));
    wait_frames(1);

    check("dut3 scan finished", dut3_done, 1);
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hex_display_mux.md
Name: hex_display_mux

Overview:
Parametrised multiplexed 7-segment driver for common-anode displays with NUM_DIGITS digits.
- Scans digits with a free-running dwell counter.
- Decodes each nibble to segments, with an optional decimal point per digit.
- Adds PWM brightness, leading-zero blanking and tear-free frame-synchronous data update.
- Sits between the register/status logic and the board display pins; it is the next-generation replacement for the fixed 4-digit driver.

Parameters:
- NUM_DIGITS, 4: digits driven; legal range 1..16.
- CNT_WIDTH, 14: dwell counter width; each digit is active for 2^CNT_WIDTH clocks. Must be >= BRIGHT_WIDTH.
- BRIGHT_WIDTH, 4: width of the brightness control.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_data  in  4*NUM_DIGITS  hex nibbles; digit k = i_data[4k+3:4k]; digit 0 is rightmost
- i_dp  in  NUM_DIGITS  decimal point per digit
- i_load  in  1  strobe; captures i_data/i_dp into the staging register
- i_brightness  in  BRIGHT_WIDTH  PWM duty; 0 = dark
- i_blank_lz  in  1  enable leading-zero blanking
- o_anodes  out  NUM_DIGITS  active-low digit enables
- o_segments  out  8  active-high; bit7..bit1 = a..g, bit0 = dp
- o_frame  out  1  one-cycle pulse at frame boundary
- o_pending  out  1  staged data not yet displayed

Behaviour:
Reset values:
- o_anodes all 1, o_segments 0, o_frame 0, o_pending 0.
- Dwell counter 0, digit index 0, staging 0, shadow 0.

Scan:
- Dwell counter increments every clk.
- At all-ones it wraps and the digit index advances: 0,1,..,NUM_DIGITS-1,0. Non-power-of-two NUM_DIGITS wraps explicitly.
- Index width = max(1, clog2(NUM_DIGITS)).

Frame boundary:
- Defined as the cycle where the index wraps NUM_DIGITS-1 -> 0 (dwell counter at all-ones).
- With NUM_DIGITS=1, every dwell wrap is a frame boundary.
- o_frame is registered: high during the first cycle of the new frame.

Load handshake:
- i_load=1 copies i_data/i_dp into staging and sets pending. Repeated loads overwrite staging; last one wins.
- At a frame boundary with pending=1, staging is copied into shadow and pending is cleared.
- i_load coincident with a frame boundary: the new value goes into staging, is copied to shadow at that same boundary, and pending ends 0.
- The display always shows the shadow, so a whole frame is shown from one data set.

Brightness:
- Digit active iff cnt[CNT_WIDTH-1 -: BRIGHT_WIDTH] < i_brightness.
- Duty = i_brightness / 2^BRIGHT_WIDTH. i_brightness is sampled live.

Leading-zero blanking:
- Applies when i_blank_lz=1.
- Digit k is blanked when k != 0 and shadow nibbles k..NUM_DIGITS-1 are all 0 and the dp of each of those digits is 0.
- Digit 0 is never blanked.

Outputs:
- Registered; 1 clk latency from the counter/index.
- Active digit: o_anodes = ~(1<<index), o_segments = decode | dp.
- Inactive (PWM off or blanked): o_anodes all 1, o_segments 0.

Decode (a..g in bits 7..1):
- 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
- 8=FE, 9=F6, A=EE, B=3E, C=9C, D=7A, E=9E, F=8E

Reset mid-operation:
- Immediate return to reset values. Staged data is lost and pending is cleared.

Optional Feature:
HEX_DISPLAY_DP_EN:
- Defined: i_dp is staged/shadowed with i_data, drives o_segments[0] of the active digit, and participates in the blanking rule.
- Undefined: i_dp is ignored (port remains), no dp storage, o_segments[0] is always 0, and blanking depends on nibbles only.

Test Plan:
1. Reset, then release with i_brightness=0: o_anodes=4'b1111 and o_segments=0 for all cycles; o_frame pulses every 4*2^CNT_WIDTH clocks.
2. CNT_WIDTH=4, BRIGHT_WIDTH=4, brightness=15, load 16'h12A4, wait one frame: digit0 shows o_anodes=1110, segs=66 for 15 of 16 cycles, off 1; digits 1..3 show EE, DA, 60.
3. Load 16'h0000 mid-frame while showing 16'hFFFF: 8E is shown until the frame boundary, o_pending=1 until then; the next frame shows FC on all digits and o_pending=0.
4. i_blank_lz=1, data 16'h0050: digits 3 and 2 keep anodes high all frame; digits 1 and 0 show B6 and FC. Data 0: only digit 0 is lit.
5. NUM_DIGITS=3: index sequence 0,1,2,0; o_anodes 110,101,011; o_frame once per 3*2^CNT_WIDTH clocks.
6. With HEX_DISPLAY_DP_EN, i_dp=4'b1000 and data 0: digit 3 is not blanked and shows FD. Without the macro, digit 3 is blanked and bit0 is always 0. Apply rst_n low mid-frame: outputs return to reset values at once.
